// File: rtl/skew_sequencer.sv
// skew_sequencer: clocking-block controller for a D -> FF -> INV -> Q loop.
// Walking-one drive through an output delay line, Q sampled via a history buffer.
module skew_sequencer #(
  parameter  int WIDTH        = 8,
  parameter  int MAX_IN_SKEW  = 4,
  parameter  int MAX_OUT_SKEW = 4,
  parameter  int LOOP_LAT     = 1,
  localparam int IW = $clog2(MAX_IN_SKEW + 1),
  localparam int OW = $clog2(MAX_OUT_SKEW + 1),
  localparam int SW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IW-1:0]    in_skew,
  input  logic [OW-1:0]    out_skew,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] d_out,
  output logic [WIDTH-1:0] cb_d,
  output logic [WIDTH-1:0] cb_q,
  output logic [SW-1:0]    step,
  output logic             busy,
  output logic             done
);

  localparam int DW =
    $clog2(MAX_IN_SKEW + MAX_OUT_SKEW + LOOP_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cb_d_q, cb_d_d;
  logic [WIDTH-1:0] cb_q_q, cb_q_d;
  logic [SW-1:0]    step_q, step_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [IW-1:0]    in_skew_q, in_skew_d;
  logic [OW-1:0]    out_skew_q, out_skew_d;
  logic [WIDTH-1:0] hist_q  [MAX_IN_SKEW];
  logic [WIDTH-1:0] hist_d  [MAX_IN_SKEW];
  logic [WIDTH-1:0] dline_q [MAX_OUT_SKEW];
  logic [WIDTH-1:0] dline_d [MAX_OUT_SKEW];

  always_comb begin
    state_d    = state_q;
    cb_d_d     = cb_d_q;
    step_d     = step_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    drain_d    = drain_q;
    in_skew_d  = in_skew_q;
    out_skew_d = out_skew_q;

    hist_d[0] = q_in;
    for (int i = 1; i < MAX_IN_SKEW; i++)
      hist_d[i] = hist_q[i-1];
    dline_d[0] = cb_d_q;
    for (int i = 1; i < MAX_OUT_SKEW; i++)
      dline_d[i] = dline_q[i-1];

    cb_q_d = q_in;
    for (int i = 0; i < MAX_IN_SKEW; i++)
      if (in_skew_q == IW'(i + 1))
        cb_q_d = hist_q[i];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          cb_d_d  = '0;
          step_d  = '0;
          busy_d  = 1'b1;
          in_skew_d = (in_skew > IW'(MAX_IN_SKEW))
                    ? IW'(MAX_IN_SKEW) : in_skew;
          out_skew_d = (out_skew > OW'(MAX_OUT_SKEW))
                     ? OW'(MAX_OUT_SKEW) : out_skew;
        end
      end
      DRIVE: begin
        cb_d_d = WIDTH'(1) << step_q;
        step_d = step_q + SW'(1);
        if (step_q == SW'(WIDTH - 1)) begin
          state_d = DRAIN;
          drain_d = DW'(out_skew_q) + DW'(LOOP_LAT)
                  + DW'(in_skew_q);
        end
      end
      DRAIN: begin
        drain_d = drain_q - DW'(1);
        // counter is about to reach zero: end of sequence
        if (drain_q <= DW'(1)) begin
          state_d = IDLE;
          drain_d = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cb_d_d  = '0;
          step_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cb_d_q     <= '0;
      cb_q_q     <= '0;
      step_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      drain_q    <= '0;
      in_skew_q  <= '0;
      out_skew_q <= '0;
      for (int i = 0; i < MAX_IN_SKEW; i++)
        hist_q[i] <= '0;
      for (int i = 0; i < MAX_OUT_SKEW; i++)
        dline_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cb_d_q     <= cb_d_d;
      cb_q_q     <= cb_q_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      drain_q    <= drain_d;
      in_skew_q  <= in_skew_d;
      out_skew_q <= out_skew_d;
      for (int i = 0; i < MAX_IN_SKEW; i++)
        hist_q[i] <= hist_d[i];
      for (int i = 0; i < MAX_OUT_SKEW; i++)
        dline_q[i] <= dline_d[i];
    end
  end

  // d_out is a mux over flops only, so it clears with async reset
  always_comb begin
    d_out = cb_d_q;
    for (int i = 0; i < MAX_OUT_SKEW; i++)
      if (out_skew_q == OW'(i + 1))
        d_out = dline_q[i];
  end

  assign cb_d = cb_d_q;
  assign cb_q = cb_q_q;
  assign step = step_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
